// File: rtl/dma_sched_pkg.sv
// Shared types and register offsets for the DMA request scheduler.
package dma_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_SRC,
    WR_DST,
    WR_LEN,
    WR_START,
    WAIT_DONE,
    CLR_START,
    RELEASE,
    COMPLETE
  } sched_state_t;

  localparam logic [31:0] DMA_OFS_SRC   = 32'h1000;
  localparam logic [31:0] DMA_OFS_DST   = 32'h2000;
  localparam logic [31:0] DMA_OFS_LEN   = 32'h3000;
  localparam logic [31:0] DMA_OFS_START = 32'h4000;

endpackage

// File: rtl/dma_req_scheduler_rr_arbiter.sv
// Round-robin arbiter for the DMA request scheduler.
// With DMA_SCHED_PRIO_EN defined, requester 0 always wins when it is
// requesting and the others share round-robin among themselves.
module rr_arbiter
  import dma_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic [NUM_REQ-1:0] rr_req;
  logic               found;
  int                 idx;

  // Search from the slot after the last winner; grant only when enabled.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    rr_req    = req;
`ifdef DMA_SCHED_PRIO_EN
    rr_req[0] = 1'b0;
    if (req[0]) begin
      found = 1'b1;
    end
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && rr_req[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
    if (en && found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/dma_req_scheduler.sv
// Shares one DMA controller among NUM_REQ requesters: accepts a descriptor,
// programs the DMA registers, waits for done, clears start, and pulses
// a per-requester completion.
// Optional build macro: DMA_SCHED_PRIO_EN (requester 0 fixed priority).
//
// state     | meaning
// IDLE      | arbitrating, req_ready driven for the winner
// WR_SRC    | write source address register
// WR_DST    | write destination address register
// WR_LEN    | write length register
// WR_START  | write 1 to start register
// WAIT_DONE | waiting for dma_done to rise
// CLR_START | write 0 to start register
// RELEASE   | waiting for dma_done to fall (DMA back in INIT)
// COMPLETE  | one-cycle cmp_valid pulse to the owner
module dma_req_scheduler
  import dma_sched_pkg::*;
#(
  parameter int          NUM_REQ      = 2,
  parameter logic [31:0] DMA_REG_BASE = 32'h5000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_src,
  input  logic [NUM_REQ*32-1:0]      req_dst,
  input  logic [NUM_REQ*32-1:0]      req_len,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         cmp_valid,
  input  logic                       dma_done,
  output logic [3:0]                 dmareg_wen,
  output logic [31:0]                dmareg_addr,
  output logic [31:0]                dmareg_data,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  sched_state_t       state, next_state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     gid_q;
  logic [31:0]        src_q, dst_q, len_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_en;
  logic               accept;
  int                 sel_base;
  logic [31:0]        sel_len;

  // Gate with rst so req_ready is 0 while reset is held.
  assign arb_en   = (state == IDLE) && !rst;
  assign accept   = |arb_grant;
  assign sel_base = 32 * int'(arb_idx);
  assign sel_len  = req_len[sel_base +: 32];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign req_ready = arb_grant;
  assign busy      = (state != IDLE);
  assign grant_id  = gid_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Latch the descriptor and owner on accept; advance round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IDW'(NUM_REQ - 1);
      gid_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
    end else if (accept) begin
      gid_q <= arb_idx;
      src_q <= req_src[sel_base +: 32];
      dst_q <= req_dst[sel_base +: 32];
      len_q <= sel_len;
`ifdef DMA_SCHED_PRIO_EN
      if (arb_idx != '0) rr_ptr <= arb_idx;
`else
      rr_ptr <= arb_idx;
`endif
    end
  end

  // Next-state and per-state register writes / completion pulse.
  always_comb begin
    next_state  = state;
    dmareg_wen  = 4'b0000;
    dmareg_addr = '0;
    dmareg_data = '0;
    cmp_valid   = '0;
    case (state)
      IDLE: begin
        if (accept) next_state = (sel_len != '0) ? WR_SRC : COMPLETE;
      end
      WR_SRC: begin
        dmareg_wen  = 4'b1111;
        dmareg_addr = DMA_REG_BASE + DMA_OFS_SRC;
        dmareg_data = src_q;
        next_state  = WR_DST;
      end
      WR_DST: begin
        dmareg_wen  = 4'b1111;
        dmareg_addr = DMA_REG_BASE + DMA_OFS_DST;
        dmareg_data = dst_q;
        next_state  = WR_LEN;
      end
      WR_LEN: begin
        dmareg_wen  = 4'b1111;
        dmareg_addr = DMA_REG_BASE + DMA_OFS_LEN;
        dmareg_data = len_q;
        next_state  = WR_START;
      end
      WR_START: begin
        dmareg_wen  = 4'b1111;
        dmareg_addr = DMA_REG_BASE + DMA_OFS_START;
        dmareg_data = 32'd1;
        next_state  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (dma_done) next_state = CLR_START;
      end
      CLR_START: begin
        dmareg_wen  = 4'b1111;
        dmareg_addr = DMA_REG_BASE + DMA_OFS_START;
        dmareg_data = 32'd0;
        next_state  = RELEASE;
      end
      RELEASE: begin
        if (!dma_done) next_state = COMPLETE;
      end
      COMPLETE: begin
        cmp_valid[gid_q] = 1'b1;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_req_scheduler.sv
// Self-checking bench for dma_req_scheduler (NUM_REQ=2).
module tb_dma_req_scheduler;

  localparam int          N    = 2;
  localparam logic [31:0] BASE = 32'h5000_0000;
`ifdef DMA_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_src = '0, req_dst = '0, req_len = '0;
  logic [N-1:0]    req_ready, cmp_valid;
  logic            dma_done = 1'b0;
  logic [3:0]      dmareg_wen;
  logic [31:0]     dmareg_addr, dmareg_data;
  logic            busy;
  logic [0:0]      grant_id;

  dma_req_scheduler #(.NUM_REQ(N), .DMA_REG_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_src(req_src),
    .req_dst(req_dst), .req_len(req_len), .req_ready(req_ready),
    .cmp_valid(cmp_valid), .dma_done(dma_done), .dmareg_wen(dmareg_wen),
    .dmareg_addr(dmareg_addr), .dmareg_data(dmareg_data), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction script: each accepted descriptor expands to the list of
  // cycles it must produce on the outputs.
  // kind 0 = register write, 1 = hold until done high, 2 = hold until done low, 3 = completion
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } slot_t;

  slot_t mq[$];
  int    m_rr    = N - 1;
  int    m_owner = 0;

  logic [63:0] wr_log[$];
  int          wr_cyc[$];
  int          gnt_log[$];
  int          gnt_cyc[$];
  int          cmp_log[$];
  int          cmp_cyc[$];
  int          last_hi = 0;
  bit          start_seen = 1'b0;

  function automatic int pick();
    if (PRIO && req_valid[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (!(PRIO && i == 0) && req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic void plan(input int w);
    logic [31:0] s, d, l;
    s = req_src[32*w +: 32];
    d = req_dst[32*w +: 32];
    l = req_len[32*w +: 32];
    if (l != 0) begin
      mq.push_back('{0, BASE + 32'h1000, s});
      mq.push_back('{0, BASE + 32'h2000, d});
      mq.push_back('{0, BASE + 32'h3000, l});
      mq.push_back('{0, BASE + 32'h4000, 32'd1});
      mq.push_back('{1, 32'd0, 32'd0});
      mq.push_back('{0, BASE + 32'h4000, 32'd0});
      mq.push_back('{2, 32'd0, 32'd0});
    end
    mq.push_back('{3, 32'd0, 32'd0});
  endfunction

  // Model compare and event logging, once per cycle on the falling edge.
  always @(negedge clk) begin : mdl
    logic [N-1:0] e_ready, e_cmp;
    logic [3:0]   e_wen;
    logic [31:0]  e_addr, e_data;
    logic         e_busy;
    int           w;
    cyc++;
    e_ready = '0; e_cmp = '0; e_wen = '0; e_addr = '0; e_data = '0; e_busy = 1'b0;
    if (rst) begin
      mq.delete();
      m_rr = N - 1;
      chk("rst_grant_id", grant_id, 0);
    end else if (mq.size() == 0) begin
      w = pick();
      if (w >= 0) begin
        e_ready[w] = 1'b1;
        plan(w);
        m_owner = w;
        if (!PRIO || w != 0) m_rr = w;
      end
    end else begin
      e_busy = 1'b1;
      if (mq[0].kind == 0) begin
        e_wen = 4'hF; e_addr = mq[0].addr; e_data = mq[0].data;
      end
      if (mq[0].kind == 3) e_cmp[m_owner] = 1'b1;
      chk("grant_id", grant_id, m_owner);
      if ((mq[0].kind == 1 && dma_done) || (mq[0].kind == 2 && !dma_done) ||
          mq[0].kind == 0 || mq[0].kind == 3)
        void'(mq.pop_front());
    end
    chk("req_ready", req_ready, e_ready);
    chk("cmp_valid", cmp_valid, e_cmp);
    chk("dmareg_wen", dmareg_wen, e_wen);
    chk("dmareg_addr", dmareg_addr, e_addr);
    chk("dmareg_data", dmareg_data, e_data);
    chk("busy", busy, e_busy);
    if (!rst) begin
      if (dmareg_wen != 0) begin
        wr_log.push_back({dmareg_addr, dmareg_data});
        wr_cyc.push_back(cyc);
      end
      if (dmareg_wen == 4'hF && dmareg_addr == BASE + 32'h4000 && dmareg_data == 32'd1)
        start_seen = 1'b1;
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) begin
          gnt_log.push_back(i);
          gnt_cyc.push_back(cyc);
        end
      if (cmp_valid != 0) begin
        cmp_log.push_back(int'(cmp_valid));
        cmp_cyc.push_back(cyc);
      end
      if (dma_done) last_hi = cyc;
    end
  end

  // DMA responder: raises done done_dly cycles after a start write, holds it done_hold cycles.
  int done_dly  = 2;
  int done_hold = 1;
  initial begin : dma_model
    int  dcnt, hcnt;
    bit  pending;
    dcnt = 0; hcnt = 0; pending = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        dma_done = 1'b0; dcnt = 0; hcnt = 0; pending = 1'b0; start_seen = 1'b0;
      end else begin
        if (hcnt > 0) begin
          hcnt--;
          if (hcnt == 0) dma_done = 1'b0;
        end else if (pending) begin
          if (dcnt == 0) begin
            dma_done = 1'b1; hcnt = done_hold; pending = 1'b0;
          end else dcnt--;
        end
        if (start_seen) begin
          pending = 1'b1; dcnt = done_dly; start_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int w, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    bit ok;
    ok = 1'b0;
    req_src[32*w +: 32] = s;
    req_dst[32*w +: 32] = d;
    req_len[32*w +: 32] = l;
    req_valid[w] = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (req_ready[w]) begin ok = 1'b1; break; end
    end
    chk("issue_accept", ok, 1);
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("idle_reached", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    wr_log.delete(); wr_cyc.delete(); gnt_log.delete(); gnt_cyc.delete();
    cmp_log.delete(); cmp_cyc.delete();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [63:0] exp_wr [5];
    int          exp_g  [4];
    int          cnt;
    int          first;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wen", dmareg_wen, 0);
    chk("rst_cmp", cmp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request from requester 0.
    clear_logs();
    done_dly = 1; done_hold = 3;
    issue(0, 32'h1000_0000, 32'h2000_0000, 32'd16);
    wait_idle();
    exp_wr = '{{32'h5000_1000, 32'h1000_0000}, {32'h5000_2000, 32'h2000_0000},
               {32'h5000_3000, 32'd16}, {32'h5000_4000, 32'd1}, {32'h5000_4000, 32'd0}};
    chk("t1_nwr", wr_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < wr_log.size()) chk("t1_wr", wr_log[k], exp_wr[k]);
    if (wr_cyc.size() >= 4) chk("t1_consecutive", wr_cyc[3] - wr_cyc[0], 3);
    chk("t1_ncmp", cmp_log.size(), 1);
    if (cmp_log.size() > 0) chk("t1_cmp", cmp_log[0], 2'b01);

    // Zero-length request from requester 1.
    clear_logs();
    done_dly = 2; done_hold = 1;
    issue(1, 32'hAAAA_0000, 32'hBBBB_0000, 32'd0);
    wait_idle();
    chk("t2_nwr", wr_log.size(), 0);
    chk("t2_ncmp", cmp_log.size(), 1);
    if (cmp_log.size() > 0) chk("t2_cmp", cmp_log[0], 2'b10);
    if (cmp_cyc.size() > 0 && gnt_cyc.size() > 0) chk("t2_latency", cmp_cyc[0] - gnt_cyc[0], 1);

    // Contention: both requesters valid for 4 transactions.
    clear_logs();
    req_src = {32'h0300_0000, 32'h0100_0000};
    req_dst = {32'h0400_0000, 32'h0200_0000};
    req_len = {32'd3, 32'd2};
    req_valid = 2'b11;
    cnt = 0;
    for (int t = 0; t < 2000 && cnt < 4; t++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        cnt++;
        chk("t3_onehot", $countones(req_ready), 1);
      end
    end
    chk("t3_grants", cnt, 4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    if (PRIO) exp_g = '{0, 0, 0, 0};
    else      exp_g = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++)
      if (k < gnt_log.size()) chk("t3_order", gnt_log[k], exp_g[k]);

    // Requester 1 arrives while requester 0 waits for done.
    clear_logs();
    done_dly = 8; done_hold = 1;
    issue(0, 32'h0500_0000, 32'h0600_0000, 32'd4);
    repeat (6) @(posedge clk); #1;
    issue(1, 32'h0700_0000, 32'h0800_0000, 32'd4);
    wait_idle();
    chk("t4_ngnt", gnt_log.size(), 2);
    if (gnt_log.size() == 2) chk("t4_second", gnt_log[1], 1);
    if (gnt_cyc.size() == 2 && cmp_cyc.size() > 0) chk("t4_first_idle", gnt_cyc[1], cmp_cyc[0] + 1);

    // Long done: held high well past CLR_START.
    clear_logs();
    done_dly = 1; done_hold = 12;
    issue(0, 32'h0900_0000, 32'h0A00_0000, 32'd3);
    wait_idle();
    chk("t5_nwr", wr_log.size(), 5);
    chk("t5_ncmp", cmp_log.size(), 1);
    if (cmp_cyc.size() > 0) chk("t5_cmp_after_fall", cmp_cyc[0], last_hi + 2);

    // Reset in WAIT_DONE.
    clear_logs();
    done_dly = 50; done_hold = 1;
    issue(0, 32'h0B00_0000, 32'h0C00_0000, 32'd8);
    repeat (8) @(posedge clk); #1;
    rst = 1'b1;
    req_src = {32'h0E00_0000, 32'h0D00_0000};
    req_dst = {32'h0E10_0000, 32'h0D10_0000};
    req_len = {32'd5, 32'd5};
    req_valid = 2'b11;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_wen", dmareg_wen, 0);
    @(posedge clk); #1;
    done_dly = 2;
    rst = 1'b0;
    first = -1;
    for (int t = 0; t < 20 && first < 0; t++) begin
      @(negedge clk);
      if (req_ready[0] && req_valid[0]) first = 0;
      else if (req_ready[1] && req_valid[1]) first = 1;
    end
    chk("t6_first_winner", first, 0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    chk("t6_ncmp", cmp_log.size(), 1);
    if (cmp_log.size() > 0) chk("t6_cmp", cmp_log[0], 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
